// File: rtl/store_truncate_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : store_truncate_unit_if
// Description : Request and word-memory bus bundle for store_truncate_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_truncate_unit_if;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_wr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ack;

    // Requester plus memory side: drives requests and memory responses.
    modport master (
        output start, size, addr, data_in, mem_rd_data, mem_rd_valid, mem_wr_ack,
        input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wr_data
    );

    modport slave (
        input  start, size, addr, data_in, mem_rd_data, mem_rd_valid, mem_wr_ack,
        output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/store_truncate_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_truncate_unit
// Description : Sub-word store via read-merge-write on a 32-bit word memory.
//               Define STORE_ALIGN_CHECK_EN to reject misaligned/reserved stores.
// Revision    : 1.0 - initial release
// ============================================================================
module store_truncate_unit (
    input  wire logic            clk,
    input  wire logic            rst,
    store_truncate_unit_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [15:0] r_data;
    logic [31:0] r_rdata;
    logic [31:0] r_wr_data;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_rd;
    logic        r_wr;

    logic        w_word;
    logic        w_misalign;
    logic [31:0] w_merged;

    // Size 11 falls into the word path when alignment checking is off.
    assign w_word = bus.size[1];

`ifdef STORE_ALIGN_CHECK_EN
    assign w_misalign = (bus.size == 2'b11)
                     || ((bus.size == 2'b01) && bus.addr[0])
                     || ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Little-endian lane replacement; only byte and halfword reach MERGE.
    always_comb begin
        w_merged = r_rdata;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_data[7:0];
                2'd1:    w_merged[15:8]  = r_data[7:0];
                2'd2:    w_merged[23:16] = r_data[7:0];
                default: w_merged[31:24] = r_data[7:0];
            endcase
        end else begin
            if (r_addr[1]) w_merged[31:16] = r_data;
            else           w_merged[15:0]  = r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_size    <= 2'b00;
            r_addr    <= 32'h0;
            r_data    <= 16'h0;
            r_rdata   <= 32'h0;
            r_wr_data <= 32'h0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_size <= bus.size;
                        r_addr <= bus.addr;
                        r_data <= bus.data_in[15:0];
                        r_busy <= 1'b1;
                        if (w_misalign) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (w_word) begin
                            r_state   <= ST_WR;
                            r_wr      <= 1'b1;
                            r_wr_data <= bus.data_in;
                        end else begin
                            r_state <= ST_RD;
                            r_rd    <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (bus.mem_rd_valid) begin
                        r_rdata <= bus.mem_rd_data;
                        r_rd    <= 1'b0;
                        r_state <= ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    r_wr_data <= w_merged;
                    r_wr      <= 1'b1;
                    r_state   <= ST_WR;
                end
                ST_WR: begin
                    if (bus.mem_wr_ack) begin
                        r_wr    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.mem_addr    = {r_addr[31:2], 2'b00};
    assign bus.mem_rd      = r_rd;
    assign bus.mem_wr      = r_wr;
    assign bus.mem_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_store_truncate_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_truncate_unit
// Description : Randomized self-checking bench with a byte-lane memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_truncate_unit;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] mem [0:15];

    store_truncate_unit_if bus ();

    store_truncate_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit model_misalign(input logic [1:0] sz, input logic [31:0] a);
`ifdef STORE_ALIGN_CHECK_EN
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Byte b of the word takes source byte src from the store data when enabled.
    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        int lane;
        w    = old;
        lane = int'(a % 4);
        for (int b = 0; b < 4; b++) begin
            bit en;
            int src;
            if (sz == 2'd0)      begin en = (b == lane);         src = 0;     end
            else if (sz == 2'd1) begin en = (b / 2 == lane / 2); src = b % 2; end
            else                 begin en = 1'b1;                src = b;     end
            if (en) w = (w & ~(32'hFF << (8 * b))) | (((d >> (8 * src)) & 32'hFF) << (8 * b));
        end
        return w;
    endfunction

    task automatic drive_idle();
        bus.start        = 1'b0;
        bus.size         = 2'd0;
        bus.addr         = 32'h0;
        bus.data_in      = 32'h0;
        bus.mem_rd_data  = 32'h0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_wr_ack   = 1'b0;
    endtask

    task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                             input int rdd, input int wrd);
        int          idx;
        bit          mis;
        bit          rd_path;
        logic [31:0] expw;
        int          rdc, wrc, donec, ndone;
        bit          overlap, busylow, addr_bad, unstable;
        logic [31:0] wdata;
        logic        err_seen, busy_after;
        idx      = int'((a - 32'h100) >> 2);
        mis      = model_misalign(sz, a);
        rd_path  = !mis && (sz == 2'd0 || sz == 2'd1);
        expw     = model_merge(mem[idx], sz, a, d);
        rdc = 0; wrc = 0; donec = -1; ndone = 0;
        overlap = 0; busylow = 0; addr_bad = 0; unstable = 0;
        wdata = 32'h0; err_seen = 1'b0; busy_after = 1'b1;

        bus.start   = 1'b1;
        bus.size    = sz;
        bus.addr    = a;
        bus.data_in = d;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            if (donec >= 0) begin
                busy_after = bus.busy;
                if (bus.done) ndone++;
                break;
            end
            if (bus.mem_rd && bus.mem_wr) overlap = 1;
            if (!bus.busy) busylow = 1;
            bus.mem_rd_valid = 1'b0;
            bus.mem_wr_ack   = 1'b0;
            bus.mem_rd_data  = $urandom;
            if (bus.mem_rd) begin
                rdc++;
                if (bus.mem_addr !== ((a >> 2) << 2)) addr_bad = 1;
                if (rdc > rdd) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_rd_data  = mem[idx];
                end
            end
            if (bus.mem_wr) begin
                wrc++;
                if (bus.mem_addr !== ((a >> 2) << 2)) addr_bad = 1;
                if (wrc > 1 && bus.mem_wr_data !== wdata) unstable = 1;
                wdata = bus.mem_wr_data;
                if (wrc > wrd) bus.mem_wr_ack = 1'b1;
            end
            if (bus.done) begin
                ndone++;
                donec    = cyc;
                err_seen = bus.err;
            end
            // Garbage requests while busy must not disturb the captured operands.
            if (donec < 0) begin
                bus.start   = 1'($urandom % 2);
                bus.size    = 2'($urandom % 4);
                bus.addr    = $urandom;
                bus.data_in = $urandom;
            end else begin
                bus.start = 1'b0;
            end
        end
        drive_idle();

        check_eq("done_count", ndone, 1);
        check_eq("err", {31'h0, err_seen}, {31'h0, mis});
        check_eq("rd_cycles", rdc, rd_path ? rdd + 1 : 0);
        check_eq("wr_cycles", wrc, mis ? 0 : wrd + 1);
        if (mis)          check_eq("done_cycle", donec, 1);
        else if (rd_path) check_eq("done_cycle", donec, rdd + wrd + 4);
        else              check_eq("done_cycle", donec, wrd + 2);
        if (!mis)         check_eq("wr_data", wdata, expw);
        check_eq("rd_wr_overlap", {31'h0, overlap}, 0);
        check_eq("busy_low_early", {31'h0, busylow}, 0);
        check_eq("mem_addr", {31'h0, addr_bad}, 0);
        check_eq("wr_data_stable", {31'h0, unstable}, 0);
        check_eq("busy_after_done", {31'h0, busy_after}, 0);
        if (!mis) mem[idx] = expw;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'h0, bus.busy}, 0);
        check_eq("rst_done", {31'h0, bus.done}, 0);
        check_eq("rst_err", {31'h0, bus.err}, 0);
        check_eq("rst_mem_rd", {31'h0, bus.mem_rd}, 0);
        check_eq("rst_mem_wr", {31'h0, bus.mem_wr}, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_mem_wr_data", bus.mem_wr_data, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios on the word at 0x100.
        mem[0] = 32'h11223344;
        run_store(2'd0, 32'h102, 32'hFFFFFFAA, 0, 0);
        check_eq("byte_mem", mem[0], 32'h11AA3344);
        mem[0] = 32'h11223344;
        run_store(2'd1, 32'h102, 32'h1234BEEF, 0, 0);
        check_eq("half_mem", mem[0], 32'hBEEF3344);
        run_store(2'd2, 32'h104, 32'hDEADBEEF, 0, 0);
        check_eq("word_mem", mem[1], 32'hDEADBEEF);
        run_store(2'd0, 32'h109, 32'h00000055, 3, 2);
        mem[0] = 32'h11223344;
        run_store(2'd1, 32'h101, 32'h0000CAFE, 0, 0);
        run_store(2'd3, 32'h10C, 32'h87654321, 1, 1);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            a = 32'h100 + 32'($urandom_range(0, 63));
            run_store(2'($urandom % 4), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while waiting in WR for an acknowledge.
        begin
            bit saw_wr;
            int ndone;
            saw_wr = 0;
            ndone  = 0;
            bus.start = 1'b1; bus.size = 2'd0; bus.addr = 32'h110; bus.data_in = 32'h77;
            for (int c = 0; c < 10 && !saw_wr; c++) begin
                @(posedge clk); #1;
                bus.start        = 1'b0;
                bus.mem_rd_valid = bus.mem_rd;
                bus.mem_rd_data  = mem[4];
                if (bus.mem_wr) saw_wr = 1;
            end
            check_eq("reach_wr", {31'h0, saw_wr}, 1);
            bus.mem_rd_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_eq("rst_wr_mem_wr", {31'h0, bus.mem_wr}, 0);
            check_eq("rst_wr_busy", {31'h0, bus.busy}, 0);
            for (int c = 0; c < 4; c++) begin
                if (bus.done) ndone++;
                @(posedge clk); #1;
            end
            check_eq("rst_wr_no_done", ndone, 0);
        end

        // Start coincident with reset is ignored.
        rst = 1'b1; bus.start = 1'b1; bus.size = 2'd2; bus.addr = 32'h100;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_start_busy", {31'h0, bus.busy}, 0);
        check_eq("rst_start_mem_wr", {31'h0, bus.mem_wr}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
